execute_lane_serializer: RTL and testbench

- Accepts one full-warp execute packet (NUM_THREADS lanes) from dispatch and emits it as NUM_BATCHES = NUM_THREADS/NUM_LANES lane-slices to a NUM_LANES-wide functional unit.
- Tags each slice with pid/sop/eop; the FU reassembles the slices on the commit side.
- Sits between the operand collector and the ALU/FPU/LSU execute ports; registered output, one packet in flight.

---
 rtl/execute_lane_serializer.sv | 152 +++++++++++++++
 tb/tb_execute_lane_serializer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_lane_serializer.sv
// Splits one NUM_THREADS-wide execute packet into NUM_THREADS/NUM_LANES registered lane slices.
// Optional build macro EXECUTE_SKIP_EMPTY_SLICE_EN: slices whose tmask is all zero are not emitted.
module execute_lane_serializer #(
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 2,
  parameter int META_W      = 96,
  parameter int XLEN        = 32,
  parameter int PID_WIDTH   = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  // Valid/ready: a transfer happens on a rising clk edge where valid && ready; the source holds
  // its payload stable while valid && !ready, and valid never depends combinationally on ready.
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [META_W-1:0]              in_meta,
  input  logic [NUM_THREADS-1:0]         in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0]    in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0]    in_rs2_data,
  input  logic [NUM_THREADS*XLEN-1:0]    in_rs3_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [META_W-1:0]              out_meta,
  output logic [NUM_LANES-1:0]           out_tmask,
  output logic [NUM_LANES*XLEN-1:0]      out_rs1_data,
  output logic [NUM_LANES*XLEN-1:0]      out_rs2_data,
  output logic [NUM_LANES*XLEN-1:0]      out_rs3_data,
  output logic [PID_WIDTH-1:0]           out_pid,
  output logic                           out_sop,
  output logic                           out_eop
);

  localparam int NUM_BATCHES = NUM_THREADS / NUM_LANES;
  localparam int SLICE_W     = NUM_LANES * XLEN;
  localparam int DATA_W      = NUM_THREADS * XLEN;

  typedef enum logic {IDLE, SPLIT} state_t;
  state_t state_q, state_d;

  logic [NUM_THREADS-1:0] pkt_tmask;
  logic [DATA_W-1:0]      pkt_rs1, pkt_rs2, pkt_rs3;
  logic [NUM_BATCHES-1:0] ne_in, ne_pkt;
  logic                   out_fire, in_fire;
  logic                   first_eop, next_eop;
  int                     first_i, next_i;

`ifdef EXECUTE_SKIP_EMPTY_SLICE_EN
  function automatic logic [NUM_BATCHES-1:0] slice_mask(input logic [NUM_THREADS-1:0] m);
    logic [NUM_BATCHES-1:0] r;
    for (int b = 0; b < NUM_BATCHES; b++) r[b] = |m[b*NUM_LANES +: NUM_LANES];
    return r;
  endfunction
`endif

  // Priority encoder: lowest emitted slice strictly above 'after', or -1 when none remains.
  function automatic int find_above(input logic [NUM_BATCHES-1:0] ne, input int after);
    int r;
    r = -1;
    for (int b = NUM_BATCHES - 1; b >= 0; b--) begin
      if (ne[b] && (b > after)) r = b;
    end
    return r;
  endfunction

  function automatic logic [SLICE_W-1:0] data_slice(input logic [DATA_W-1:0] d, input int p);
    return d[p*SLICE_W +: SLICE_W];
  endfunction

  assign out_fire = out_valid && out_ready;
  assign in_ready = !reset && ((state_q == IDLE) || (out_fire && out_eop));
  assign in_fire  = in_valid && in_ready;

  always_comb begin
`ifdef EXECUTE_SKIP_EMPTY_SLICE_EN
    ne_in  = slice_mask(in_tmask);
    ne_pkt = slice_mask(pkt_tmask);
`else
    ne_in  = '1;
    ne_pkt = '1;
`endif
    // An all-empty packet still emits slice 0 so the FU sees one sop/eop beat.
    first_i = find_above(ne_in, -1);
    if (first_i < 0) first_i = 0;
    first_eop = (find_above(ne_in, first_i) < 0);
    next_i = find_above(ne_pkt, int'(out_pid));
    if (next_i < 0) next_i = 0;
    next_eop = (find_above(ne_pkt, next_i) < 0);
  end

  always_comb begin
    state_d = state_q;
    if (in_fire)                   state_d = SPLIT;
    else if (out_fire && out_eop)  state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_tmask    <= '0;
      pkt_rs1      <= '0;
      pkt_rs2      <= '0;
      pkt_rs3      <= '0;
      out_valid    <= 1'b0;
      out_meta     <= '0;
      out_tmask    <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rs3_data <= '0;
      out_pid      <= '0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
    end else if (in_fire) begin
      pkt_tmask    <= in_tmask;
      pkt_rs1      <= in_rs1_data;
      pkt_rs2      <= in_rs2_data;
      pkt_rs3      <= in_rs3_data;
      out_valid    <= 1'b1;
      out_meta     <= in_meta;
      out_tmask    <= in_tmask[first_i*NUM_LANES +: NUM_LANES];
      out_rs1_data <= data_slice(in_rs1_data, first_i);
      out_rs2_data <= data_slice(in_rs2_data, first_i);
      out_rs3_data <= data_slice(in_rs3_data, first_i);
      out_pid      <= PID_WIDTH'(first_i);
      out_sop      <= 1'b1;
      out_eop      <= first_eop;
    end else if (out_fire) begin
      if (out_eop) begin
        out_valid <= 1'b0;
      end else begin
        out_tmask    <= pkt_tmask[next_i*NUM_LANES +: NUM_LANES];
        out_rs1_data <= data_slice(pkt_rs1, next_i);
        out_rs2_data <= data_slice(pkt_rs2, next_i);
        out_rs3_data <= data_slice(pkt_rs3, next_i);
        out_pid      <= PID_WIDTH'(next_i);
        out_sop      <= 1'b0;
        out_eop      <= next_eop;
      end
    end
  end

  a_out_hold: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> $stable({out_valid, out_meta, out_tmask, out_rs1_data,
                                           out_rs2_data, out_rs3_data, out_pid, out_sop, out_eop}));

  a_meta_on_fire: assert property (@(posedge clk) disable iff (reset)
    !in_fire |=> $stable(out_meta));

endmodule

// File: tb/tb_execute_lane_serializer.sv
// Randomized bench for execute_lane_serializer: slice-list reference model plus a 4x4 pass-through instance.
module tb_execute_lane_serializer;

  localparam int NT = 8;
  localparam int NL = 2;
  localparam int MW = 96;
  localparam int XL = 32;
  localparam int NB = NT / NL;
  localparam int PW = 2;
  localparam int SW = MW + NL + 3 * NL * XL + PW + 2;

  logic clk = 1'b0;
  logic reset;

  logic             in_valid, in_ready;
  logic [MW-1:0]    in_meta;
  logic [NT-1:0]    in_tmask;
  logic [NT*XL-1:0] in_rs1_data, in_rs2_data, in_rs3_data;
  logic             out_valid, out_ready;
  logic [MW-1:0]    out_meta;
  logic [NL-1:0]    out_tmask;
  logic [NL*XL-1:0] out_rs1_data, out_rs2_data, out_rs3_data;
  logic [PW-1:0]    out_pid;
  logic             out_sop, out_eop;

  logic             in4_valid, in4_ready;
  logic [MW-1:0]    in4_meta;
  logic [3:0]       in4_tmask;
  logic [4*XL-1:0]  in4_rs1, in4_rs2, in4_rs3;
  logic             out4_valid, out4_ready;
  logic [MW-1:0]    out4_meta;
  logic [3:0]       out4_tmask;
  logic [4*XL-1:0]  out4_rs1, out4_rs2, out4_rs3;
  logic [0:0]       out4_pid;
  logic             out4_sop, out4_eop;

  execute_lane_serializer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_meta(in_meta), .in_tmask(in_tmask),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rs3_data(in_rs3_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_meta(out_meta), .out_tmask(out_tmask),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rs3_data(out_rs3_data),
    .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop)
  );

  execute_lane_serializer #(.NUM_THREADS(4), .NUM_LANES(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in4_valid), .in_ready(in4_ready), .in_meta(in4_meta), .in_tmask(in4_tmask),
    .in_rs1_data(in4_rs1), .in_rs2_data(in4_rs2), .in_rs3_data(in4_rs3),
    .out_valid(out4_valid), .out_ready(out4_ready), .out_meta(out4_meta), .out_tmask(out4_tmask),
    .out_rs1_data(out4_rs1), .out_rs2_data(out4_rs2), .out_rs3_data(out4_rs3),
    .out_pid(out4_pid), .out_sop(out4_sop), .out_eop(out4_eop)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [SW-1:0] exp_q[$];

  task automatic push_packet(input logic [MW-1:0] m, input logic [NT-1:0] t,
                             input logic [NT*XL-1:0] a, input logic [NT*XL-1:0] b,
                             input logic [NT*XL-1:0] c);
    int sel[$];
    int p;
    for (int s = 0; s < NB; s++) begin
`ifdef EXECUTE_SKIP_EMPTY_SLICE_EN
      if (t[s*NL +: NL] != '0) sel.push_back(s);
`else
      sel.push_back(s);
`endif
    end
    if (sel.size() == 0) sel.push_back(0);
    for (int k = 0; k < sel.size(); k++) begin
      p = sel[k];
      exp_q.push_back({m, t[p*NL +: NL], a[p*NL*XL +: NL*XL], b[p*NL*XL +: NL*XL],
                       c[p*NL*XL +: NL*XL], PW'(p), (k == 0), (k == sel.size() - 1)});
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [SW-1:0] obs;
  assign obs = {out_meta, out_tmask, out_rs1_data, out_rs2_data, out_rs3_data, out_pid, out_sop, out_eop};

  bit            mon_en = 1'b0;
  bit            prev_stall = 1'b0;
  logic [SW-1:0] prev_obs;
  int            fire_count = 0;

  always @(negedge clk) begin
    if (!reset && mon_en) begin
      check_eq("out_valid", out_valid, exp_q.size() != 0);
      check_eq("in_ready", in_ready,
               (exp_q.size() == 0) || (out_valid && out_ready && exp_q.size() == 1));
      if (prev_stall) check_eq("stall_hold", {out_valid, obs}, {1'b1, prev_obs});
      if (out_valid && out_ready) begin
        fire_count++;
        if (exp_q.size() != 0) check_eq("slice", obs, exp_q.pop_front());
      end
      if (in_valid && in_ready) push_packet(in_meta, in_tmask, in_rs1_data, in_rs2_data, in_rs3_data);
      prev_stall = out_valid && !out_ready;
      prev_obs   = obs;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pkt(input logic [NT-1:0] t);
    in_meta  = {$urandom, $urandom, $urandom};
    in_tmask = t;
    for (int i = 0; i < NT; i++) begin
      in_rs1_data[i*XL +: XL] = $urandom;
      in_rs2_data[i*XL +: XL] = $urandom;
      in_rs3_data[i*XL +: XL] = $urandom;
    end
  endtask

  function automatic logic [NT-1:0] pick_mask();
    logic [NT-1:0] m;
    case ($urandom_range(0, 4))
      0:       m = '1;
      1:       m = '0;
      2:       m = NT'(3) << (2 * $urandom_range(0, NB - 1));
      default: m = NT'($urandom);
    endcase
    return m;
  endfunction

  task automatic send_pkt(input bit keep);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    check_eq("accept", acc, 1'b1);
    if (!keep) in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f0;
    bit acc;
    logic [MW-1:0]   p_meta;
    logic [3:0]      p_tmask;
    logic [4*XL-1:0] p_rs1, p_rs2, p_rs3;

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; in_meta = '0; in_tmask = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_rs3_data = '0;
    in4_valid = 1'b0; out4_ready = 1'b1; in4_meta = '0; in4_tmask = '0;
    in4_rs1 = '0; in4_rs2 = '0; in4_rs3 = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_outputs", obs, '0);
    check_eq("rst_in_ready", in_ready, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("in_ready_after_rst", in_ready, 1'b1);
    mon_en = 1'b1;

    // full mask, rs1 lane i = i, out_ready held high
    rand_pkt('1);
    for (int i = 0; i < NT; i++) in_rs1_data[i*XL +: XL] = XL'(i);
    send_pkt(1'b0);
    repeat (5) tick();

    // back-to-back packets with no bubble
    rand_pkt('1);
    send_pkt(1'b1);
    f0 = fire_count;
    rand_pkt('1);
    send_pkt(1'b0);
    repeat (4) tick();
    check_eq("b2b_fires", fire_count - f0, 8);

    // backpressure while pid 1 is presented
    rand_pkt('1);
    send_pkt(1'b0);
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    check_eq("stall_pid", out_pid, 1);
    out_ready = 1'b1;
    repeat (4) tick();

    // sparse and empty masks
    rand_pkt(8'b0011_0000);
    send_pkt(1'b0);
    repeat (5) tick();
    rand_pkt('0);
    send_pkt(1'b0);
    repeat (5) tick();

    // reset after pid 1 fires
    rand_pkt('1);
    send_pkt(1'b0);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check_eq("midrst_out_valid", out_valid, 1'b0);
    check_eq("midrst_outputs", obs, '0);
    check_eq("midrst_in_ready", in_ready, 1'b0);
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    rand_pkt('1);
    send_pkt(1'b0);
    repeat (5) tick();

    // randomized traffic with random backpressure
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        in_valid = $urandom_range(0, 1);
        rand_pkt(pick_mask());
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
    check_eq("drain", exp_q.size(), 0);

    // single-batch configuration: registered pass-through
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) begin
        in4_valid = 1'b1;
        in4_meta  = {$urandom, $urandom, $urandom};
        in4_tmask = 4'($urandom);
        in4_rs1   = {$urandom, $urandom, $urandom, $urandom};
        in4_rs2   = {$urandom, $urandom, $urandom, $urandom};
        in4_rs3   = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in4_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 6) check_eq("p4_in_ready", in4_ready, 1'b1);
      if (k > 0) begin
        check_eq("p4_flags", {out4_valid, out4_pid, out4_sop, out4_eop, out4_tmask},
                 {1'b1, 1'b0, 1'b1, 1'b1, p_tmask});
        check_eq("p4_meta", out4_meta, p_meta);
        check_eq("p4_rs1", out4_rs1, p_rs1);
        check_eq("p4_rs2", out4_rs2, p_rs2);
        check_eq("p4_rs3", out4_rs3, p_rs3);
      end
      p_meta = in4_meta; p_tmask = in4_tmask;
      p_rs1 = in4_rs1; p_rs2 = in4_rs2; p_rs3 = in4_rs3;
      tick();
    end
    @(negedge clk);
    check_eq("p4_idle", out4_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
